// File: rtl/mat_conv_param.sv
// Run-time configurable 2-D convolution core: latches a kernel, walks the output grid,
// reads image pixels from a synchronous memory and streams results over valid/ready.
module mat_conv_param #(
    parameter int IMG_M        = 10,
    parameter int IMG_N        = 12,
    parameter int K_MAX        = 5,
    parameter int DATA_WIDTH   = 4,
    parameter int KERNEL_WIDTH = 4,
    parameter int ACC_WIDTH    = 16,
    parameter int CNT_WIDTH    = 16,
    localparam int RW = $clog2(IMG_M),
    localparam int CW = $clog2(IMG_N),
    localparam int KW = $clog2(K_MAX*K_MAX+1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [2:0]              cfg_ksize,
    input  logic                    cfg_stride2,
    input  logic                    cfg_same,
    output logic                    cfg_err,
    input  logic [KERNEL_WIDTH-1:0] kernel_in,
    input  logic                    kernel_valid,
    output logic                    kernel_ready,
    output logic                    img_rd_en,
    output logic [RW-1:0]           img_row,
    output logic [CW-1:0]           img_col,
    input  logic [DATA_WIDTH-1:0]   img_rdata,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ACC_WIDTH-1:0]    out_elem,
    output logic [RW-1:0]           out_row_idx,
    output logic [CW-1:0]           out_col_idx,
    output logic                    out_row_end,
    output logic                    out_last,
    output logic                    busy,
    output logic                    done,
    output logic [CNT_WIDTH-1:0]    cycle_count
);
    localparam int PW = DATA_WIDTH + KERNEL_WIDTH;

    typedef enum logic [2:0] {IDLE, LOAD, CALC, EMIT, DONE} state_t;
    state_t state_q, state_d;

    logic [K_MAX*K_MAX-1:0][KERNEL_WIDTH-1:0] kmem;
    logic [2:0]              ksize_q, pad_q, ky_q, kx_q;
    logic                    stride2_q;
    logic [KW-1:0]           kk_q, kcnt_q, tap_q;
    logic [RW-1:0]           row_last_q, r_q;
    logic [CW-1:0]           col_last_q, c_q;
    logic                    rd_q, cfg_err_q, done_q;
    logic [KERNEL_WIDTH-1:0] kv_q;
    logic [ACC_WIDTH-1:0]    acc_q;
    logic [CNT_WIDTH-1:0]    cnt_q;

    // Config decode for a start request
    logic       cfg_bad, idle_like, start_ok;
    logic [2:0] pad_new;
    int         om_new, on_new;
    always_comb begin
        cfg_bad = (cfg_ksize == 3'd0) || !cfg_ksize[0] || (int'(cfg_ksize) > K_MAX) ||
                  (!cfg_same && (int'(cfg_ksize) > IMG_M || int'(cfg_ksize) > IMG_N));
        pad_new = cfg_same ? ((cfg_ksize - 3'd1) >> 1) : 3'd0;
        if (cfg_same) begin
            om_new = cfg_stride2 ? (IMG_M + 1) / 2 : IMG_M;
            on_new = cfg_stride2 ? (IMG_N + 1) / 2 : IMG_N;
        end else begin
            om_new = cfg_stride2 ? (IMG_M - int'(cfg_ksize)) / 2 + 1 : IMG_M - int'(cfg_ksize) + 1;
            on_new = cfg_stride2 ? (IMG_N - int'(cfg_ksize)) / 2 + 1 : IMG_N - int'(cfg_ksize) + 1;
        end
    end
    assign idle_like = (state_q == IDLE) || (state_q == DONE);
    assign start_ok  = start && idle_like && !cfg_bad;

    // Tap address: window origin may be negative in same mode
    int   ir, ic;
    logic inb, tap_live, row_end, last;
    always_comb begin
        ir  = int'(r_q) * (stride2_q ? 2 : 1) - int'(pad_q) + int'(ky_q);
        ic  = int'(c_q) * (stride2_q ? 2 : 1) - int'(pad_q) + int'(kx_q);
        inb = (ir >= 0) && (ir < IMG_M) && (ic >= 0) && (ic < IMG_N);
    end
    assign tap_live  = (state_q == CALC) && (tap_q != kk_q);
    assign img_rd_en = tap_live && inb;
    assign img_row   = ir[RW-1:0];
    assign img_col   = ic[CW-1:0];
    assign row_end   = (c_q == col_last_q);
    assign last      = row_end && (r_q == row_last_q);

    logic [PW-1:0] prod;
    assign prod = PW'(img_rdata) * PW'(kv_q);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (start_ok) state_d = LOAD;
            LOAD:       if (kernel_valid && kcnt_q == kk_q - KW'(1)) state_d = CALC;
            CALC:       if (tap_q == kk_q) state_d = EMIT;
            EMIT:       if (out_ready) state_d = last ? DONE : CALC;
            default:    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (state_q == LOAD && kernel_valid) kmem[kcnt_q] <= kernel_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ksize_q    <= '0;
            pad_q      <= '0;
            stride2_q  <= 1'b0;
            kk_q       <= '0;
            row_last_q <= '0;
            col_last_q <= '0;
            kcnt_q     <= '0;
            tap_q      <= '0;
            ky_q       <= '0;
            kx_q       <= '0;
            r_q        <= '0;
            c_q        <= '0;
            rd_q       <= 1'b0;
            kv_q       <= '0;
            acc_q      <= '0;
            cfg_err_q  <= 1'b0;
            done_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q   <= state_d;
            cfg_err_q <= start && idle_like && cfg_bad;
            done_q    <= (state_q == EMIT) && out_ready && last;
            rd_q      <= img_rd_en;
            case (state_q)
                IDLE, DONE: if (start_ok) begin
                    ksize_q    <= cfg_ksize;
                    stride2_q  <= cfg_stride2;
                    pad_q      <= pad_new;
                    kk_q       <= KW'(int'(cfg_ksize) * int'(cfg_ksize));
                    row_last_q <= RW'(om_new - 1);
                    col_last_q <= CW'(on_new - 1);
                    kcnt_q     <= '0;
                    r_q        <= '0;
                    c_q        <= '0;
                end
                LOAD: begin
                    if (kernel_valid) kcnt_q <= kcnt_q + KW'(1);
                    tap_q <= '0;
                    ky_q  <= '0;
                    kx_q  <= '0;
                    acc_q <= '0;
                end
                CALC: begin
                    if (tap_live) begin
                        kv_q  <= kmem[tap_q];
                        tap_q <= tap_q + KW'(1);
                        if (kx_q == ksize_q - 3'd1) begin
                            kx_q <= '0;
                            ky_q <= ky_q + 3'd1;
                        end else begin
                            kx_q <= kx_q + 3'd1;
                        end
                    end
                    // product of the tap issued last cycle; skipped taps add nothing
                    if (rd_q) acc_q <= acc_q + ACC_WIDTH'(prod);
                end
                EMIT: if (out_ready && !last) begin
                    tap_q <= '0;
                    ky_q  <= '0;
                    kx_q  <= '0;
                    acc_q <= '0;
                    if (row_end) begin
                        c_q <= '0;
                        r_q <= r_q + RW'(1);
                    end else begin
                        c_q <= c_q + CW'(1);
                    end
                end
                default: ;
            endcase
            if (start_ok) cnt_q <= '0;
            else if (state_q == CALC || state_q == EMIT) cnt_q <= cnt_q + CNT_WIDTH'(1);
        end
    end

    assign cfg_err      = cfg_err_q;
    assign kernel_ready = (state_q == LOAD);
    assign out_valid    = (state_q == EMIT);
    assign out_elem     = acc_q;
    assign out_row_idx  = r_q;
    assign out_col_idx  = c_q;
    assign out_row_end  = out_valid && row_end;
    assign out_last     = out_valid && last;
    assign busy         = (state_q == CALC) || (state_q == EMIT);
    assign done         = done_q;
    assign cycle_count  = cnt_q;
endmodule
